// File: rtl/cw305_usb_bus_master.sv
// Host-side initiator for the CW305 USB parallel register bus.
// Runs 1..2^pBYTECNT_SIZE byte read/write bursts using SETUP/STROBE/HOLD timing.
module cw305_usb_bus_master #(
   parameter int pBYTECNT_SIZE = 7,
   parameter int pADDR_WIDTH   = 21,
   parameter int pSETUP        = 1,
   parameter int pSTROBE       = 3,
   parameter int pHOLD         = 1
) (
   input  logic                                 usb_clk,
   input  logic                                 rst,
   input  logic                                 cmd_valid,
   output logic                                 cmd_ready,
   input  logic                                 cmd_write,
   input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] cmd_addr,
   input  logic [pBYTECNT_SIZE-1:0]             cmd_len,
   input  logic [7:0]                           wr_data,
   input  logic                                 wr_valid,
   output logic                                 wr_ready,
   output logic [7:0]                           rd_data,
   output logic                                 rd_valid,
   output logic                                 busy,
   output logic [pADDR_WIDTH-1:0]               bus_addr,
   output logic [7:0]                           bus_data_out,
   output logic                                 bus_data_oe,
   input  logic [7:0]                           bus_data_in,
   output logic                                 bus_ncs,
   output logic                                 bus_nrd,
   output logic                                 bus_nwe
);

   localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;
   localparam int BW = pBYTECNT_SIZE;
   localparam int CW = 8;

   localparam logic [CW-1:0] SETUP_LAST  = CW'(pSETUP - 1);
   localparam logic [CW-1:0] STROBE_LAST = CW'(pSTROBE - 1);
   localparam logic [CW-1:0] HOLD_LAST   = CW'(pHOLD - 1);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic             r_write;
   logic [AW-1:0]    r_addr;
   logic [BW-1:0]    r_len;
   logic [BW-1:0]    r_idx;
   logic             r_loaded;
   logic             r_wr_ready;
   logic [7:0]       r_rd_data;
   logic             r_rd_valid;
   logic [pADDR_WIDTH-1:0] r_bus_addr;
   logic [7:0]       r_dout;
   logic             r_oe;
   logic             r_ncs;
   logic             r_nrd;
   logic             r_nwe;
   logic [BW-1:0]    w_idx_next;

   assign w_idx_next = r_idx + BW'(1);

   assign cmd_ready    = (r_state == S_IDLE);
   assign busy         = (r_state != S_IDLE);
   assign wr_ready     = r_wr_ready;
   assign rd_data      = r_rd_data;
   assign rd_valid     = r_rd_valid;
   assign bus_addr     = r_bus_addr;
   assign bus_data_out = r_dout;
   assign bus_data_oe  = r_oe;
   assign bus_ncs      = r_ncs;
   assign bus_nrd      = r_nrd;
   assign bus_nwe      = r_nwe;

   always_ff @(posedge usb_clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_write    <= 1'b0;
         r_addr     <= '0;
         r_len      <= '0;
         r_idx      <= '0;
         r_loaded   <= 1'b0;
         r_wr_ready <= 1'b0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_bus_addr <= '0;
         r_dout     <= '0;
         r_oe       <= 1'b0;
         r_ncs      <= 1'b1;
         r_nrd      <= 1'b1;
         r_nwe      <= 1'b1;
      end else begin
         r_wr_ready <= 1'b0;
         r_rd_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_write    <= cmd_write;
                  r_addr     <= cmd_addr;
                  r_len      <= cmd_len;
                  r_idx      <= '0;
                  r_cnt      <= '0;
                  r_bus_addr <= {cmd_addr, BW'(0)};
                  r_state    <= S_SETUP;
                  if (!cmd_write) begin
                     r_ncs    <= 1'b0;
                     r_loaded <= 1'b1;
                  end else if (wr_valid) begin
                     r_ncs      <= 1'b0;
                     r_oe       <= 1'b1;
                     r_dout     <= wr_data;
                     r_wr_ready <= 1'b1;
                     r_loaded   <= 1'b1;
                  end else begin
                     r_loaded <= 1'b0;
                  end
               end
            end
            S_SETUP: begin
               // A write byte without data parks here with the bus released;
               // the setup count only starts once the byte is latched.
               if (!r_loaded) begin
                  if (wr_valid) begin
                     r_ncs      <= 1'b0;
                     r_oe       <= 1'b1;
                     r_dout     <= wr_data;
                     r_wr_ready <= 1'b1;
                     r_loaded   <= 1'b1;
                     r_cnt      <= '0;
                  end
               end else if (r_cnt == SETUP_LAST) begin
                  r_cnt   <= '0;
                  r_state <= S_STROBE;
                  if (r_write) r_nwe <= 1'b0;
                  else         r_nrd <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_STROBE: begin
               if (r_cnt == STROBE_LAST) begin
                  r_cnt   <= '0;
                  r_state <= S_HOLD;
                  r_nwe   <= 1'b1;
                  r_nrd   <= 1'b1;
                  if (!r_write) begin
                     r_rd_data  <= bus_data_in;
                     r_rd_valid <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_HOLD: begin
               if (r_cnt == HOLD_LAST) begin
                  r_cnt <= '0;
                  if (r_idx == r_len) begin
                     r_state <= S_IDLE;
                     r_ncs   <= 1'b1;
                     r_oe    <= 1'b0;
                  end else begin
                     r_idx      <= w_idx_next;
                     r_bus_addr <= {r_addr, w_idx_next};
                     r_state    <= S_SETUP;
                     if (!r_write) begin
                        r_loaded <= 1'b1;
                     end else if (wr_valid) begin
                        r_dout     <= wr_data;
                        r_wr_ready <= 1'b1;
                        r_loaded   <= 1'b1;
                     end else begin
                        r_loaded <= 1'b0;
                        r_ncs    <= 1'b1;
                        r_oe     <= 1'b0;
                     end
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cw305_usb_bus_master.sv
// Directed bench for cw305_usb_bus_master: bus timing, bursts, stalls, reset, back-to-back.
module tb_cw305_usb_bus_master;

   localparam int BW = 7;
   localparam int AW = 14;

   logic          usb_clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [BW-1:0] cmd_len = '0;
   logic [7:0]    wr_data = '0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [7:0]    rd_data;
   logic          rd_valid;
   logic          busy;
   logic [20:0]   bus_addr;
   logic [7:0]    bus_data_out;
   logic          bus_data_oe;
   logic [7:0]    bus_data_in;
   logic          bus_ncs;
   logic          bus_nrd;
   logic          bus_nwe;

   int checks = 0;
   int errors = 0;

   cw305_usb_bus_master dut (
      .usb_clk(usb_clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
      .bus_addr(bus_addr), .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe),
      .bus_data_in(bus_data_in), .bus_ncs(bus_ncs), .bus_nrd(bus_nrd), .bus_nwe(bus_nwe)
   );

   always #5 usb_clk = ~usb_clk;

   // Responder drives 0x10+idx only while nRD is low, so a late sample is visible.
   assign bus_data_in = bus_nrd ? 8'hEE : (8'h10 + {1'b0, bus_addr[6:0]});

   logic cur_write = 1'b0;

   a_strobes: assert property (@(posedge usb_clk) disable iff (rst) !(!bus_nrd && !bus_nwe));
   a_ncs:     assert property (@(posedge usb_clk) disable iff (rst) ((!bus_nrd || !bus_nwe) |-> !bus_ncs));
   a_oe_rd:   assert property (@(posedge usb_clk) disable iff (rst) (!cur_write |-> !bus_data_oe));
   a_stable:  assert property (@(posedge usb_clk) disable iff (rst)
                 ((!bus_nwe || !bus_nrd) |=> ((bus_nwe && bus_nrd) || ($stable(bus_addr) && $stable(bus_data_out)))));

   int n_we_pulse, n_we_cyc, n_oe_cyc, n_oe_wo_ncs, n_ncs_hi_busy, n_wr_ready, n_busy, n_ready_busy;
   logic [7:0]  wq[$];
   logic [20:0] waq[$];
   logic [7:0]  rq[$];
   logic [6:0]  raq[$];
   logic        prev_nwe, prev_nrd;
   logic [7:0]  wbytes[$];

   task automatic clear_obs();
      n_we_pulse = 0; n_we_cyc = 0; n_oe_cyc = 0; n_oe_wo_ncs = 0;
      n_ncs_hi_busy = 0; n_wr_ready = 0; n_busy = 0; n_ready_busy = 0;
      wq.delete(); waq.delete(); rq.delete(); raq.delete();
      prev_nwe = 1'b1; prev_nrd = 1'b1;
   endtask

   task automatic sample();
      if (!bus_nwe) n_we_cyc++;
      if (!bus_nwe && prev_nwe) begin
         n_we_pulse++;
         wq.push_back(bus_data_out);
         waq.push_back(bus_addr);
      end
      if (!bus_nrd && prev_nrd) raq.push_back(bus_addr[6:0]);
      if (bus_data_oe) n_oe_cyc++;
      if (bus_data_oe && bus_ncs) n_oe_wo_ncs++;
      if (busy && bus_ncs) n_ncs_hi_busy++;
      if (busy && cmd_ready) n_ready_busy++;
      if (rd_valid) rq.push_back(rd_data);
      if (wr_ready) n_wr_ready++;
      if (busy) n_busy++;
      prev_nwe = bus_nwe;
      prev_nrd = bus_nrd;
   endtask

   task automatic drive_wr(input logic wr, input int ptr, input int len, input int stall_at, inout int left);
      if (!wr || ptr > len) wr_valid = 1'b0;
      else if (ptr == stall_at && left > 0) begin
         wr_valid = 1'b0;
         left--;
      end else begin
         wr_valid = 1'b1;
         wr_data  = wbytes[ptr];
      end
   endtask

   task automatic run_cmd(input logic wr, input logic [AW-1:0] a, input logic [BW-1:0] len,
                          input int stall_at, input int stall_n, output bit timeout);
      int ptr, left, cyc;
      ptr = 0; left = stall_n; cyc = 0;
      clear_obs();
      @(negedge usb_clk);
      cur_write = wr;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = len;
      drive_wr(wr, ptr, int'(len), stall_at, left);
      do begin
         @(negedge usb_clk);
         cmd_valid = 1'b0;
         sample();
         if (wr_ready) ptr++;
         drive_wr(wr, ptr, int'(len), stall_at, left);
         cyc++;
      end while ((busy || cyc < 2) && cyc < 3000);
      wr_valid = 1'b0;
      timeout = (cyc >= 3000);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge usb_clk);
      checks++;
      if ({bus_ncs, bus_nrd, bus_nwe, bus_data_oe, rd_valid, wr_ready, busy, cmd_ready} !== 8'b1110_0001) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 11100001",
                  {bus_ncs, bus_nrd, bus_nwe, bus_data_oe, rd_valid, wr_ready, busy, cmd_ready});
      end
      checks++;
      if ({bus_addr, bus_data_out, rd_data} !== 37'd0) begin
         errors++;
         $display("FAIL reset_data got addr %h dout %h rd %h want 0", bus_addr, bus_data_out, rd_data);
      end
      rst = 1'b0;
   endtask

   task automatic test_single_write();
      bit to;
      wbytes = '{8'hA5};
      run_cmd(1'b1, 14'h05, 7'd0, -1, 0, to);
      checks++; if (to) begin errors++; $display("FAIL sw_timeout got 1 want 0"); end
      checks++; if (n_we_pulse != 1) begin errors++; $display("FAIL sw_pulses got %0d want 1", n_we_pulse); end
      checks++; if (n_we_cyc != 3) begin errors++; $display("FAIL sw_nwe_len got %0d want 3", n_we_cyc); end
      if (waq.size() == 1) begin
         checks++; if (waq[0] !== 21'h00280) begin errors++; $display("FAIL sw_addr got %h want 00280", waq[0]); end
         checks++; if (wq[0] !== 8'hA5) begin errors++; $display("FAIL sw_data got %h want a5", wq[0]); end
      end
      checks++; if (n_oe_cyc != 5) begin errors++; $display("FAIL sw_oe_cyc got %0d want 5", n_oe_cyc); end
      checks++; if (n_oe_wo_ncs != 0) begin errors++; $display("FAIL sw_oe_no_cs got %0d want 0", n_oe_wo_ncs); end
      checks++; if (n_wr_ready != 1) begin errors++; $display("FAIL sw_wr_ready got %0d want 1", n_wr_ready); end
      checks++; if (n_busy != 5) begin errors++; $display("FAIL sw_busy got %0d want 5", n_busy); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL sw_ready got %b want 1", cmd_ready); end
   endtask

   task automatic test_read_burst();
      bit to;
      run_cmd(1'b0, 14'h03, 7'd3, -1, 0, to);
      checks++; if (to) begin errors++; $display("FAIL rb_timeout got 1 want 0"); end
      checks++; if (rq.size() != 4) begin errors++; $display("FAIL rb_count got %0d want 4", rq.size()); end
      for (int i = 0; i < 4 && i < rq.size(); i++) begin
         checks++;
         if (rq[i] !== 8'(8'h10 + i)) begin errors++; $display("FAIL rb_data[%0d] got %h want %h", i, rq[i], 8'(8'h10 + i)); end
      end
      for (int i = 0; i < 4 && i < raq.size(); i++) begin
         checks++;
         if (raq[i] !== 7'(i)) begin errors++; $display("FAIL rb_idx[%0d] got %h want %h", i, raq[i], 7'(i)); end
      end
      checks++; if (n_oe_cyc != 0) begin errors++; $display("FAIL rb_oe got %0d want 0", n_oe_cyc); end
      checks++; if (n_busy != 20) begin errors++; $display("FAIL rb_busy got %0d want 20", n_busy); end
   endtask

   task automatic test_write_stall();
      bit to;
      wbytes = '{8'h11, 8'h22, 8'h33};
      run_cmd(1'b1, 14'h1234, 7'd2, 1, 8, to);
      checks++; if (to) begin errors++; $display("FAIL ws_timeout got 1 want 0"); end
      checks++; if (n_we_pulse != 3) begin errors++; $display("FAIL ws_pulses got %0d want 3", n_we_pulse); end
      for (int i = 0; i < 3 && i < wq.size(); i++) begin
         checks++;
         if (wq[i] !== wbytes[i] || waq[i] !== {14'h1234, 7'(i)}) begin
            errors++;
            $display("FAIL ws_byte[%0d] got %h@%h want %h@%h", i, wq[i], waq[i], wbytes[i], {14'h1234, 7'(i)});
         end
      end
      checks++; if (n_ncs_hi_busy != 4) begin errors++; $display("FAIL ws_stall_ncs got %0d want 4", n_ncs_hi_busy); end
      checks++; if (n_oe_wo_ncs != 0) begin errors++; $display("FAIL ws_oe_no_cs got %0d want 0", n_oe_wo_ncs); end
      checks++; if (n_wr_ready != 3) begin errors++; $display("FAIL ws_wr_ready got %0d want 3", n_wr_ready); end
      checks++; if (n_busy != 19) begin errors++; $display("FAIL ws_busy got %0d want 19", n_busy); end
   endtask

   task automatic test_max_burst();
      bit to;
      int bad;
      bad = 0;
      run_cmd(1'b0, 14'h002A, 7'h7F, -1, 0, to);
      checks++; if (to) begin errors++; $display("FAIL mb_timeout got 1 want 0"); end
      checks++; if (rq.size() != 128) begin errors++; $display("FAIL mb_count got %0d want 128", rq.size()); end
      for (int i = 0; i < rq.size(); i++) if (rq[i] !== 8'(8'h10 + i)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL mb_data got %0d bad bytes want 0", bad); end
      checks++;
      if (raq.size() != 128 || raq[127] !== 7'h7F) begin
         errors++; $display("FAIL mb_last_idx got %0d strobes want 128 ending 7f", raq.size());
      end
      checks++; if (n_busy != 640) begin errors++; $display("FAIL mb_busy got %0d want 640", n_busy); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mb_ready got %b want 1", cmd_ready); end
   endtask

   task automatic test_reset_mid();
      bit to;
      int cyc, stray;
      cyc = 0; stray = 0;
      @(negedge usb_clk);
      cur_write = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 14'h0042; cmd_len = 7'd3;
      wr_valid = 1'b1; wr_data = 8'h5A;
      do begin
         @(negedge usb_clk);
         cmd_valid = 1'b0;
         cyc++;
      end while (bus_nwe && cyc < 20);
      checks++; if (bus_nwe !== 1'b0) begin errors++; $display("FAIL rm_strobe got nwe %b want 0", bus_nwe); end
      rst = 1'b1;
      #1;
      checks++;
      if ({bus_ncs, bus_nwe, bus_data_oe, busy} !== 4'b1100) begin
         errors++; $display("FAIL rm_release got %b want 1100", {bus_ncs, bus_nwe, bus_data_oe, busy});
      end
      repeat (2) @(negedge usb_clk);
      rst = 1'b0;
      repeat (10) begin
         @(negedge usb_clk);
         if (wr_ready || rd_valid || !bus_ncs || !bus_nwe || busy) stray++;
      end
      checks++; if (stray != 0) begin errors++; $display("FAIL rm_stray got %0d want 0", stray); end
      wr_valid = 1'b0;
      wbytes = '{8'hC3};
      run_cmd(1'b1, 14'h0011, 7'd0, -1, 0, to);
      checks++;
      if (to || n_we_pulse != 1 || wq.size() != 1 || wq[0] !== 8'hC3 || waq[0] !== 21'h00880) begin
         errors++; $display("FAIL rm_next got %0d pulses want 1 of c3@00880", n_we_pulse);
      end
   endtask

   task automatic test_back_to_back();
      logic hist[30];
      logic ncsh[30];
      int bad, cyc;
      bad = 0; cyc = 0;
      clear_obs();
      @(negedge usb_clk);
      cur_write = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 14'h0009; cmd_len = 7'd0;
      for (int k = 0; k < 30; k++) begin
         @(negedge usb_clk);
         sample();
         hist[k] = busy;
         ncsh[k] = bus_ncs;
      end
      cmd_valid = 1'b0;
      while (busy && cyc < 50) begin @(negedge usb_clk); cyc++; end
      for (int k = 0; k < 30; k++) if (hist[k] !== ((k % 6) != 5)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL b2b_busy got %0d bad cycles want 0", bad); end
      bad = 0;
      for (int k = 0; k < 30; k++) if (ncsh[k] !== ((k % 6) == 5)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL b2b_ncs_gap got %0d bad cycles want 0", bad); end
      checks++; if (rq.size() != 5) begin errors++; $display("FAIL b2b_rd_count got %0d want 5", rq.size()); end
      bad = 0;
      for (int i = 0; i < rq.size(); i++) if (rq[i] !== 8'h10) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL b2b_rd_data got %0d bad want 0", bad); end
      checks++; if (n_ready_busy != 0) begin errors++; $display("FAIL b2b_ready_busy got %0d want 0", n_ready_busy); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain got busy %b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read_burst();
      test_write_stall();
      test_max_burst();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
